// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : IF stage. Fetches aligned 64-bit pairs, predecodes branches and
//             hands 0/1/2 instructions to the instruction buffer. The optional
//             static backward-taken/forward-not-taken prediction is built when
//             FETCH_BTFN_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  input  logic        instbuf_full,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  issue,
  output logic        stop,
  output logic [31:0] out1_inst,
  output logic [31:0] out1_pc,
  output logic [31:0] out1_npc,
  output logic        out1_isbranch,
  output logic        out1_br_taken,
  output logic [31:0] out2_inst,
  output logic [31:0] out2_pc,
  output logic [31:0] out2_npc,
  output logic        out2_isbranch,
  output logic        out2_br_taken
);

  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  typedef struct packed {
    logic        isbranch;
    logic        taken;
    logic [31:0] npc;
  } pdec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        isbranch;
    logic        taken;
  } slot_t;

  function automatic pdec_t predecode(input logic [31:0] inst, input logic [31:0] pc);
    pdec_t d;
    d.isbranch = (inst[6:0] == c_OP_BRANCH) || (inst[6:0] == c_OP_JAL) ||
                 (inst[6:0] == c_OP_JALR);
    d.taken    = 1'b0;
    d.npc      = pc + 32'd4;
`ifdef FETCH_BTFN_EN
    begin
      logic [31:0] imm_b;
      logic [31:0] imm_j;
      imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      if ((inst[6:0] == c_OP_BRANCH) && imm_b[31]) begin
        d.taken = 1'b1;
        d.npc   = pc + imm_b;
      end else if (inst[6:0] == c_OP_JAL) begin
        d.taken = 1'b1;
        d.npc   = pc + imm_j;
      end
    end
`endif
    return d;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [1:0]  r_issue;
  slot_t       r_slot1;
  slot_t       r_slot2;

  logic [31:0] w_inst0;
  logic [31:0] w_inst1;
  logic [31:0] w_pc1;
  pdec_t       w_dec0;
  pdec_t       w_dec1;
  logic        w_single;
  slot_t       w_pair1;
  slot_t       w_pair2;
  slot_t       w_solo;

  assign w_inst0 = imem_rdata[31:0];
  assign w_inst1 = imem_rdata[63:32];
  assign w_pc1   = {r_pc[31:3], 3'b100};
  assign w_dec0  = predecode(w_inst0, r_pc);
  assign w_dec1  = predecode(w_inst1, w_pc1);

  // Odd-word entry or a taken slot-0 prediction leaves only one useful instruction.
  assign w_single = r_pc[2] | w_dec0.taken;
  assign w_pair1  = '{inst: w_inst0, pc: r_pc, npc: w_dec0.npc,
                      isbranch: w_dec0.isbranch, taken: w_dec0.taken};
  assign w_pair2  = '{inst: w_inst1, pc: w_pc1, npc: w_dec1.npc,
                      isbranch: w_dec1.isbranch, taken: w_dec1.taken};
  assign w_solo   = r_pc[2] ? w_pair2 : w_pair1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ:   if (imem_rvalid) w_state_nxt = S_ISSUE;
      S_ISSUE: if (!instbuf_full) w_state_nxt = S_REQ;
      S_DROP:  if (imem_rvalid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
    // An outstanding request must still be drained, hence DROP from REQ.
    if (redirect) begin
      unique case (r_state)
        S_REQ:   w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        S_ISSUE: w_state_nxt = S_REQ;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_issue <= 2'b00;
      r_slot1 <= '0;
      r_slot2 <= '0;
    end else if (redirect) begin
      r_pc    <= redirect_pc;
      r_issue <= 2'b00;
      r_slot1 <= '0;
      r_slot2 <= '0;
    end else if ((r_state == S_REQ) && imem_rvalid) begin
      if (w_single) begin
        r_issue <= 2'b01;
        r_slot1 <= '0;
        r_slot2 <= w_solo;
      end else begin
        r_issue <= 2'b11;
        r_slot1 <= w_pair1;
        r_slot2 <= w_pair2;
      end
    end else if ((r_state == S_ISSUE) && !instbuf_full) begin
      // Slot 2 always carries the last issued instruction.
      r_pc    <= r_slot2.npc;
      r_issue <= 2'b00;
      r_slot1 <= '0;
      r_slot2 <= '0;
    end
  end

  assign imem_req      = (r_state == S_REQ);
  assign imem_addr     = {r_pc[31:3], 3'b000};
  assign issue         = r_issue;
  assign stop          = (r_issue == 2'b00);
  assign out1_inst     = r_slot1.inst;
  assign out1_pc       = r_slot1.pc;
  assign out1_npc      = r_slot1.npc;
  assign out1_isbranch = r_slot1.isbranch;
  assign out1_br_taken = r_slot1.taken;
  assign out2_inst     = r_slot2.inst;
  assign out2_pc       = r_slot2.pc;
  assign out2_npc      = r_slot2.npc;
  assign out2_isbranch = r_slot2.isbranch;
  assign out2_br_taken = r_slot2.taken;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch
//  Purpose  : directed self-checking bench for inst_fetch (either build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch;

`ifdef FETCH_BTFN_EN
  localparam bit c_BTFN = 1'b1;
`else
  localparam bit c_BTFN = 1'b0;
`endif

  localparam logic [31:0] c_ADDI1 = 32'h0010_8093;
  localparam logic [31:0] c_ADDI2 = 32'h0021_0113;
  localparam logic [31:0] c_BEQ   = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] c_JAL   = 32'h0400_006F;  // jal x0,+0x40
  localparam logic [31:0] c_JALR  = 32'h0000_8067;  // jalr x0,0(x1)

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic        instbuf_full = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [1:0]  issue;
  logic        stop;
  logic [31:0] out1_inst, out1_pc, out1_npc, out2_inst, out2_pc, out2_npc;
  logic        out1_isbranch, out1_br_taken, out2_isbranch, out2_br_taken;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instbuf_full(instbuf_full), .redirect(redirect), .redirect_pc(redirect_pc),
    .issue(issue), .stop(stop),
    .out1_inst(out1_inst), .out1_pc(out1_pc), .out1_npc(out1_npc),
    .out1_isbranch(out1_isbranch), .out1_br_taken(out1_br_taken),
    .out2_inst(out2_inst), .out2_pc(out2_pc), .out2_npc(out2_npc),
    .out2_isbranch(out2_isbranch), .out2_br_taken(out2_br_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slots(input string tag, input logic [1:0] iss,
                           input logic [31:0] i1, input logic [31:0] p1, input logic [31:0] n1,
                           input logic b1, input logic t1,
                           input logic [31:0] i2, input logic [31:0] p2, input logic [31:0] n2,
                           input logic b2, input logic t2);
    check({tag, ".issue"}, {issue, stop}, {iss, iss == 2'b00});
    check({tag, ".s1"}, {out1_inst, out1_pc}, {i1, p1});
    check({tag, ".s1npc"}, {out1_npc, out1_isbranch, out1_br_taken}, {n1, b1, t1});
    check({tag, ".s2"}, {out2_inst, out2_pc}, {i2, p2});
    check({tag, ".s2npc"}, {out2_npc, out2_isbranch, out2_br_taken}, {n2, b2, t2});
  endtask

  // Waits (bounded) for a request, checks its address, answers after `dly` cycles.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [63:0] data,
                       input int dly);
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    check({tag, ".req"}, imem_req, 1'b1);
    check({tag, ".addr"}, imem_addr, addr);
    for (int k = 0; k < dly; k++) begin
      step();
      check({tag, ".held"}, {imem_req, imem_addr}, {1'b1, addr});
    end
    imem_rdata  = data;
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  initial begin
    step();
    step();
    check("rst.out", {imem_req, issue, stop, out1_inst, out2_pc}, {1'b0, 2'b00, 1'b1, 64'h0});
    rst = 1'b1;
    step();
    check("rst.first_req", {imem_req, imem_addr}, {1'b1, 32'h0});

    // 1: plain pair
    serve("t1", 32'h0, {c_ADDI2, c_ADDI1}, 2);
    chk_slots("t1", 2'b11, c_ADDI1, 32'h0, 32'h4, 1'b0, 1'b0,
              c_ADDI2, 32'h4, 32'h8, 1'b0, 1'b0);
    step();
    check("t1.next", {imem_req, imem_addr, issue}, {1'b1, 32'h8, 2'b00});

    // 2: back-pressure keeps everything stable
    instbuf_full = 1'b1;
    serve("t2", 32'h8, {c_ADDI1, c_ADDI2}, 0);
    for (int k = 0; k < 3; k++) begin
      chk_slots("t2.hold", 2'b11, c_ADDI2, 32'h8, 32'hC, 1'b0, 1'b0,
                c_ADDI1, 32'hC, 32'h10, 1'b0, 1'b0);
      check("t2.noreq", imem_req, 1'b0);
      if (k < 2) step();
    end
    instbuf_full = 1'b0;
    step();
    check("t2.next", {imem_req, imem_addr, issue}, {1'b1, 32'h10, 2'b00});

    // 3: backward beq in slot 1
    serve("t3", 32'h10, {c_ADDI1, c_BEQ}, 1);
    if (c_BTFN)
      chk_slots("t3", 2'b01, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                c_BEQ, 32'h10, 32'h8, 1'b1, 1'b1);
    else
      chk_slots("t3", 2'b11, c_BEQ, 32'h10, 32'h14, 1'b1, 1'b0,
                c_ADDI1, 32'h14, 32'h18, 1'b0, 1'b0);
    step();
    check("t3.next", {imem_req, imem_addr}, {1'b1, c_BTFN ? 32'h8 : 32'h18});

    // 4: redirect while a request is outstanding
    redirect = 1'b1;
    redirect_pc = 32'h104;
    step();
    redirect = 1'b0;
    check("t4.drop", {imem_req, issue}, {1'b0, 2'b00});
    step();
    check("t4.drop_wait", imem_req, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata  = {c_BEQ, c_BEQ};
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    check("t4.discard", {imem_req, imem_addr, issue}, {1'b1, 32'h100, 2'b00});
    serve("t4b", 32'h100, {c_ADDI2, c_ADDI1}, 0);
    chk_slots("t4b", 2'b01, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
              c_ADDI2, 32'h104, 32'h108, 1'b0, 1'b0);

    // redirect in ISSUE discards the pending pair even under back-pressure
    instbuf_full = 1'b1;
    step();
    check("t4.issue_hold", issue, 2'b01);
    redirect = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    instbuf_full = 1'b0;
    check("t4.issue_redir", {imem_req, imem_addr, issue}, {1'b1, 32'h20, 2'b00});

    // 5: JAL in slot 2, JALR never predicted taken
    serve("t5", 32'h20, {c_JAL, c_ADDI1}, 1);
    chk_slots("t5", 2'b11, c_ADDI1, 32'h20, 32'h24, 1'b0, 1'b0,
              c_JAL, 32'h24, c_BTFN ? 32'h64 : 32'h28, 1'b1, c_BTFN);
    step();
    serve("t5b", c_BTFN ? 32'h60 : 32'h28, {c_JALR, c_ADDI2}, 0);
    if (c_BTFN)
      chk_slots("t5b", 2'b01, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                c_JALR, 32'h64, 32'h68, 1'b1, 1'b0);
    else
      chk_slots("t5b", 2'b11, c_ADDI2, 32'h28, 32'h2C, 1'b0, 1'b0,
                c_JALR, 32'h2C, 32'h30, 1'b1, 1'b0);

    // 6: asynchronous reset mid-ISSUE
    instbuf_full = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("t6.async", {imem_req, issue, stop, out2_inst, out2_pc}, {1'b0, 2'b00, 1'b1, 64'h0});
    step();
    rst = 1'b1;
    instbuf_full = 1'b0;
    step();
    check("t6.restart", {imem_req, imem_addr}, {1'b1, 32'h0});

    // redirect coinciding with rvalid: data dropped, straight back to REQ
    imem_rvalid = 1'b1;
    imem_rdata  = {c_ADDI1, c_ADDI2};
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    imem_rvalid = 1'b0;
    redirect = 1'b0;
    check("t7.redir_rvalid", {imem_req, imem_addr, issue}, {1'b1, 32'h40, 2'b00});

    // pc+4 wrap at the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    serve("t8", 32'hFFFF_FFF8, {c_ADDI2, c_ADDI1}, 0);
    chk_slots("t8", 2'b01, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
              c_ADDI2, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    step();
    check("t8.wrap", {imem_req, imem_addr}, {1'b1, 32'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
